// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron engine: FSM state encoding and
// a saturating adder used by the on-chip learning path.
package perceptron_pkg;

   typedef enum logic [2:0] {IDLE, MAC, DECIDE, UPDATE, OUT} state_e;

   // Adds a and b, then clamps the result to the signed range of 'width' bits.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int width);
      logic signed [32:0] s;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      s  = 33'(a) + 33'(b);
      hi = (33'sd1 <<< (width - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (width - 1));
      if (s > hi)
         return hi[31:0];
      else if (s < lo)
         return lo[31:0];
      else
         return s[31:0];
   endfunction

endpackage

// File: rtl/perceptron_weight_bank.sv
// Weight and bias storage: entries 0..N_INPUTS-1 are weights, entry N_INPUTS is
// the bias. One combinational read port, one saturating read-modify-write port.
module perceptron_weight_bank
   import perceptron_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int WEIGHT_W = 8,
   parameter int DELTA_W  = 9,
   parameter int IDX_W    = 3
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic [IDX_W-1:0]           rd_idx,
   output logic signed [WEIGHT_W-1:0] rd_data,
   input  logic                       upd_en,
   input  logic [IDX_W-1:0]           upd_idx,
   input  logic signed [DELTA_W-1:0]  upd_delta
);

   logic signed [WEIGHT_W-1:0] w_q [N_INPUTS+1];
   logic signed [31:0]         upd_sum;

   assign rd_data = w_q[rd_idx];

   always_comb begin
      upd_sum = sat_add(32'(w_q[upd_idx]), 32'(upd_delta), WEIGHT_W);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i <= N_INPUTS; i++) w_q[i] <= '0;
      end else if (upd_en) begin
         w_q[upd_idx] <= upd_sum[WEIGHT_W-1:0];
      end
   end

endmodule

// File: rtl/perceptron_core.sv
// Single-neuron perceptron: sequential MAC over the feature vector, threshold,
// and optional perceptron-rule update of the weight bank.
//
// state  | meaning
// IDLE   | ready for a vector; on accept, acc <= bias
// MAC    | acc += w[k]*x[k], one feature per cycle
// DECIDE | register sum/y, decide whether to learn
// UPDATE | w[k] += err*(x[k]>>>LR_SHIFT), then bias += err*BIAS_STEP
// OUT    | result presented until out_ready_i
module perceptron_core
   import perceptron_pkg::*;
#(
   parameter int N_INPUTS  = 4,
   parameter int DATA_W    = 8,
   parameter int WEIGHT_W  = 8,
   parameter int ACC_W     = 19,
   parameter int LR_SHIFT  = 2,
   parameter int BIAS_STEP = 1
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [N_INPUTS*DATA_W-1:0]   x_i,
   input  logic                         train_i,
   input  logic                         target_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic                         y_o,
   output logic [ACC_W-1:0]             sum_o,
   output logic                         updated_o
);

   localparam int K_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam int IDX_W   = $clog2(N_INPUTS + 1);
   localparam int DELTA_W = DATA_W + 1;
   localparam int PROD_W  = DATA_W + WEIGHT_W;
   localparam logic [K_W-1:0] K_LAST = K_W'(N_INPUTS - 1);

   state_e                      state_q, state_d;
   logic [N_INPUTS*DATA_W-1:0]  x_q;
   logic                        train_q, target_q;
   logic signed [ACC_W-1:0]     acc_q;
   logic [K_W-1:0]              k_q;
   logic                        bias_ph_q;

   logic [IDX_W-1:0]            rd_idx, upd_idx;
   logic signed [WEIGHT_W-1:0]  rd_data;
   logic signed [DATA_W-1:0]    x_sel, x_shr;
   logic signed [PROD_W-1:0]    prod;
   logic signed [DELTA_W-1:0]   upd_delta;
   logic                        upd_en;
   logic                        y_now;

   perceptron_weight_bank #(
      .N_INPUTS (N_INPUTS),
      .WEIGHT_W (WEIGHT_W),
      .DELTA_W  (DELTA_W),
      .IDX_W    (IDX_W)
   ) u_bank (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .upd_en    (upd_en),
      .upd_idx   (upd_idx),
      .upd_delta (upd_delta)
   );

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == OUT);

   // The read port serves the bias while idle so acc can be preloaded at accept.
   always_comb begin
      x_sel   = x_q[int'(k_q)*DATA_W +: DATA_W];
      x_shr   = x_sel >>> LR_SHIFT;
      prod    = rd_data * x_sel;
      y_now   = ~acc_q[ACC_W-1];
      rd_idx  = (state_q == IDLE) ? IDX_W'(N_INPUTS) : IDX_W'(k_q);
      upd_idx = bias_ph_q ? IDX_W'(N_INPUTS) : IDX_W'(k_q);
      upd_en  = (state_q == UPDATE);
      if (bias_ph_q)
         upd_delta = target_q ? DELTA_W'(BIAS_STEP) : -DELTA_W'(BIAS_STEP);
      else
         upd_delta = target_q ? DELTA_W'(x_shr) : -DELTA_W'(x_shr);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid_i) state_d = MAC;
         MAC:     if (k_q == K_LAST) state_d = DECIDE;
         DECIDE:  state_d = (train_q && (y_now != target_q)) ? UPDATE : OUT;
         UPDATE:  if (bias_ph_q) state_d = OUT;
         OUT:     if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         x_q       <= '0;
         train_q   <= 1'b0;
         target_q  <= 1'b0;
         acc_q     <= '0;
         k_q       <= '0;
         bias_ph_q <= 1'b0;
         sum_o     <= '0;
         y_o       <= 1'b0;
         updated_o <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid_i) begin
               x_q       <= x_i;
               train_q   <= train_i;
               target_q  <= target_i;
               acc_q     <= {{(ACC_W-WEIGHT_W){rd_data[WEIGHT_W-1]}}, rd_data};
               k_q       <= '0;
               bias_ph_q <= 1'b0;
            end
            MAC: begin
               acc_q <= acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
               k_q   <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            end
            DECIDE: begin
               sum_o     <= acc_q;
               y_o       <= y_now;
               updated_o <= 1'b0;
               k_q       <= '0;
               bias_ph_q <= 1'b0;
            end
            UPDATE: begin
               if (bias_ph_q)
                  updated_o <= 1'b1;
               else if (k_q == K_LAST)
                  bias_ph_q <= 1'b1;
               else
                  k_q <= k_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
